// File: rtl/light_config_loader.sv
// Configuration front end for the traffic-light controller: synchronizes and
// debounces the LOAD/NEXT buttons, steps the light selection, latches the
// switch value and issues one single-cycle enable strobe per accepted LOAD.
module light_config_loader #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_next,
    output logic [3:0] data_out,
    output logic       green_enable,
    output logic       arrow_enable,
    output logic       red_enable,
    output logic       yellow_enable,
    output logic [3:0] sel_led,
    output logic [3:0] programmed,
    output logic       all_programmed,
    output logic       err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t state, state_next;

    // Index 0 is LOAD, index 1 is NEXT.
    logic [1:0]    raw;
    logic [1:0]    sync1, sync2;
    logic [1:0]    stable, stable_q;
    logic [CW-1:0] cnt [2];
    logic [1:0]    press;
    logic          load_press, next_press;

    logic          take, reject, rotate, strobe;

    assign raw = {btn_next, btn_load};

    // Two-flop synchronizer for both raw buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous stable level, for rising-edge press detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable;
        end
    end

    assign press      = stable & ~stable_q;
    assign load_press = press[0];
    assign next_press = press[1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; LOAD takes priority over NEXT in IDLE.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        reject     = 1'b0;
        rotate     = 1'b0;
        strobe     = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_press) begin
                    if (sw != '0) begin
                        take       = 1'b1;
                        state_next = SETUP;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (next_press) begin
                    rotate = 1'b1;
                end
            end
            SETUP: begin
                state_next = STROBE;
            end
            STROBE: begin
                strobe     = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (!stable[0]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset kills them at once.
    assign green_enable  = strobe & sel_led[0];
    assign arrow_enable  = strobe & sel_led[1];
    assign red_enable    = strobe & sel_led[2];
    assign yellow_enable = strobe & sel_led[3];

    // Data latch, selection, sticky programmed/error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= '0;
            err            <= 1'b0;
            sel_led        <= 4'b0001;
            programmed     <= '0;
            all_programmed <= 1'b0;
        end else begin
            if (take) begin
                data_out <= sw;
                err      <= 1'b0;
            end
            if (reject) begin
                err <= 1'b1;
            end
            if (rotate) begin
                sel_led <= {sel_led[2:0], sel_led[3]};
            end
            if (strobe) begin
                programmed <= programmed | sel_led;
            end
            all_programmed <= &programmed;
        end
    end

endmodule

// File: tb/tb_light_config_loader.sv
// Directed self-checking bench for light_config_loader with a short debounce.
module tb_light_config_loader;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       btn_load;
    logic       btn_next;
    logic [3:0] data_out;
    logic       green_enable;
    logic       arrow_enable;
    logic       red_enable;
    logic       yellow_enable;
    logic [3:0] sel_led;
    logic [3:0] programmed;
    logic       all_programmed;
    logic       err;

    int tests = 0;
    int fails = 0;

    int n_green = 0;
    int n_arrow = 0;
    int n_red = 0;
    int n_yellow = 0;
    int n_multi = 0;

    light_config_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw             (sw),
        .btn_load       (btn_load),
        .btn_next       (btn_next),
        .data_out       (data_out),
        .green_enable   (green_enable),
        .arrow_enable   (arrow_enable),
        .red_enable     (red_enable),
        .yellow_enable  (yellow_enable),
        .sel_led        (sel_led),
        .programmed     (programmed),
        .all_programmed (all_programmed),
        .err            (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (green_enable)  n_green++;
        if (arrow_enable)  n_arrow++;
        if (red_enable)    n_red++;
        if (yellow_enable) n_yellow++;
        if ($countones({yellow_enable, red_enable, arrow_enable, green_enable}) > 1) n_multi++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_total();
        return n_green + n_arrow + n_red + n_yellow;
    endfunction

    task automatic press_next();
        btn_next = 1'b1;
        repeat (8) tick();
        btn_next = 1'b0;
        repeat (10) tick();
    endtask

    task automatic press_load(input logic [3:0] v);
        sw = v;
        btn_load = 1'b1;
        repeat (12) tick();
        btn_load = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        tests++;
        if ({yellow_enable, red_enable, arrow_enable, green_enable} !== 4'b0000) begin
            fails++; $display("FAIL reset_enables got %b exp 0000", {yellow_enable, red_enable, arrow_enable, green_enable});
        end
        tests++;
        if (data_out !== 4'd0) begin fails++; $display("FAIL reset_data got %0d exp 0", data_out); end
        tests++;
        if (sel_led !== 4'b0001) begin fails++; $display("FAIL reset_sel got %b exp 0001", sel_led); end
        tests++;
        if (programmed !== 4'b0000 || all_programmed !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL reset_flags got prog=%b all=%b err=%b exp 0000/0/0", programmed, all_programmed, err);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_accepted_load();
        int lat = 0;
        int g0 = n_green;
        int t0 = n_total();
        sw = 4'd5;
        btn_load = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (green_enable && lat == 0) lat = k;
        end
        tests++;
        if (lat !== 8) begin fails++; $display("FAIL load_latency got %0d exp 8", lat); end
        tests++;
        if (data_out !== 4'd5) begin fails++; $display("FAIL load_data got %0d exp 5", data_out); end
        tests++;
        if (n_green - g0 !== 1 || n_total() - t0 !== 1) begin
            fails++; $display("FAIL load_single_strobe got green=%0d total=%0d exp 1/1", n_green - g0, n_total() - t0);
        end
        btn_load = 1'b0;
        repeat (10) tick();
        tests++;
        if (programmed !== 4'b0001) begin fails++; $display("FAIL load_programmed got %b exp 0001", programmed); end
    endtask

    task automatic test_bounce();
        int t0 = n_total();
        sw = 4'd9;
        for (int k = 0; k < 10; k++) begin
            btn_load = ~btn_load;
            repeat (2) tick();
        end
        btn_load = 1'b0;
        repeat (10) tick();
        // 3-cycle glitch: one short of the debounce window.
        btn_load = 1'b1;
        repeat (3) tick();
        btn_load = 1'b0;
        repeat (10) tick();
        tests++;
        if (n_total() - t0 !== 0) begin fails++; $display("FAIL bounce_strobe got %0d exp 0", n_total() - t0); end
        tests++;
        if (data_out !== 4'd5) begin fails++; $display("FAIL bounce_data got %0d exp 5", data_out); end
    endtask

    task automatic test_sel_wrap();
        logic [3:0] exp_sel [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int g0, a0, r0, y0;
        for (int k = 0; k < 4; k++) begin
            press_next();
            tests++;
            if (sel_led !== exp_sel[k]) begin fails++; $display("FAIL wrap_sel%0d got %b exp %b", k, sel_led, exp_sel[k]); end
        end
        g0 = n_green; a0 = n_arrow; r0 = n_red; y0 = n_yellow;
        press_load(4'd1);
        press_next();
        press_load(4'd2);
        press_next();
        press_load(4'd3);
        press_next();
        tests++;
        if (all_programmed !== 1'b0) begin fails++; $display("FAIL wrap_allprog_early got %b exp 0", all_programmed); end
        // Yellow load stepped by hand to check the registered all_programmed timing.
        sw = 4'd4;
        btn_load = 1'b1;
        for (int k = 0; k < 30 && !yellow_enable; k++) tick();
        tick();
        tests++;
        if (programmed !== 4'b1111 || all_programmed !== 1'b0) begin
            fails++; $display("FAIL wrap_allprog_edge got prog=%b all=%b exp 1111/0", programmed, all_programmed);
        end
        tick();
        tests++;
        if (all_programmed !== 1'b1) begin fails++; $display("FAIL wrap_allprog got %b exp 1", all_programmed); end
        btn_load = 1'b0;
        repeat (10) tick();
        tests++;
        if (n_green - g0 !== 1 || n_arrow - a0 !== 1 || n_red - r0 !== 1 || n_yellow - y0 !== 1) begin
            fails++; $display("FAIL wrap_strobes got g=%0d a=%0d r=%0d y=%0d exp 1/1/1/1",
                              n_green - g0, n_arrow - a0, n_red - r0, n_yellow - y0);
        end
        tests++;
        if (data_out !== 4'd4) begin fails++; $display("FAIL wrap_data got %0d exp 4", data_out); end
        press_next();
        tests++;
        if (sel_led !== 4'b0001) begin fails++; $display("FAIL wrap_back_green got %b exp 0001", sel_led); end
    endtask

    task automatic test_zero_reject();
        int t0 = n_total();
        int g0;
        press_load(4'd0);
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL zero_err got %b exp 1", err); end
        tests++;
        if (n_total() - t0 !== 0) begin fails++; $display("FAIL zero_strobe got %0d exp 0", n_total() - t0); end
        tests++;
        if (data_out !== 4'd4) begin fails++; $display("FAIL zero_data got %0d exp 4", data_out); end
        g0 = n_green;
        press_load(4'd7);
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL zero_err_clear got %b exp 0", err); end
        tests++;
        if (n_green - g0 !== 1 || data_out !== 4'd7) begin
            fails++; $display("FAIL zero_recover got green=%0d data=%0d exp 1/7", n_green - g0, data_out);
        end
    endtask

    task automatic test_simultaneous();
        int a0, t0;
        press_next();
        tests++;
        if (sel_led !== 4'b0010) begin fails++; $display("FAIL simul_presel got %b exp 0010", sel_led); end
        a0 = n_arrow;
        t0 = n_total();
        sw = 4'd9;
        btn_load = 1'b1;
        btn_next = 1'b1;
        repeat (12) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        // Still holding LOAD: this NEXT press lands in HOLD.
        btn_next = 1'b1;
        repeat (10) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        tests++;
        if (sel_led !== 4'b0010) begin fails++; $display("FAIL simul_sel got %b exp 0010", sel_led); end
        btn_load = 1'b0;
        repeat (10) tick();
        tests++;
        if (n_arrow - a0 !== 1 || n_total() - t0 !== 1) begin
            fails++; $display("FAIL simul_strobe got arrow=%0d total=%0d exp 1/1", n_arrow - a0, n_total() - t0);
        end
        tests++;
        if (data_out !== 4'd9 || sel_led !== 4'b0010) begin
            fails++; $display("FAIL simul_final got data=%0d sel=%b exp 9/0010", data_out, sel_led);
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit seen = 1'b0;
        int t0;
        sw = 4'd3;
        btn_load = 1'b1;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            if ({yellow_enable, red_enable, arrow_enable, green_enable} != 4'b0000) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b1) begin fails++; $display("FAIL rst_strobe_seen got %b exp 1", seen); end
        rst = 1'b0;
        #1;
        tests++;
        if ({yellow_enable, red_enable, arrow_enable, green_enable} !== 4'b0000) begin
            fails++; $display("FAIL rst_kill_enables got %b exp 0000", {yellow_enable, red_enable, arrow_enable, green_enable});
        end
        tests++;
        if (data_out !== 4'd0 || sel_led !== 4'b0001 || programmed !== 4'b0000 || all_programmed !== 1'b0) begin
            fails++; $display("FAIL rst_mid_state got data=%0d sel=%b prog=%b all=%b exp 0/0001/0000/0",
                              data_out, sel_led, programmed, all_programmed);
        end
        btn_load = 1'b0;
        repeat (3) tick();
        t0 = n_total();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) tick();
        tests++;
        if (n_total() - t0 !== 0) begin fails++; $display("FAIL rst_release_strobe got %0d exp 0", n_total() - t0); end
        tests++;
        if (programmed !== 4'b0000) begin fails++; $display("FAIL rst_release_prog got %b exp 0000", programmed); end
    endtask

    task automatic test_one_hot();
        tests++;
        if (n_multi !== 0) begin fails++; $display("FAIL one_hot got %0d multi-enable cycles exp 0", n_multi); end
    endtask

    initial begin
        rst = 1'b0;
        sw = 4'd0;
        btn_load = 1'b0;
        btn_next = 1'b0;
        test_reset();
        test_accepted_load();
        test_bounce();
        test_sel_wrap();
        test_zero_reject();
        test_simultaneous();
        test_reset_mid_strobe();
        test_one_hot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/light_config_loader.md
Name: light_config_loader

Overview:
Upstream configuration stage for the traffic-light controller. It turns the board switches and two raw push-buttons into the controller's programming interface: a held 4-bit value and exactly one single-cycle enable strobe (green, arrow, red or yellow).
- The operator steps through the four lights with NEXT.
- The operator commits the switch value to the selected light with LOAD.
- The block debounces both buttons, rejects zero values, and tracks which lights have been programmed.

Parameters:
DEBOUNCE_CYCLES, 500_000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz); counter width is clog2(DEBOUNCE_CYCLES)+1.

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous, active-low reset.
sw  input  4  switch value to program.
btn_load  input  1  raw LOAD button, active-high, asynchronous to clk.
btn_next  input  1  raw NEXT button, active-high, asynchronous to clk.
data_out  output  4  value presented to the controller's data_in.
green_enable  output  1  single-cycle strobe for the green light.
arrow_enable  output  1  single-cycle strobe for the arrow light.
red_enable  output  1  single-cycle strobe for the red light.
yellow_enable  output  1  single-cycle strobe for the yellow light.
sel_led  output  4  one-hot current selection; bit order [3:0] = yellow, red, arrow, green.
programmed  output  4  sticky per-light programmed flags, same bit order as sel_led.
all_programmed  output  1  asserted when programmed == 4'b1111.
err  output  1  sticky: last LOAD attempt had sw == 0.

Behaviour:
Clock and reset:
- One clock (clk); reset is asynchronous and active-low (rst).
- Reset values: data_out=0, all four enables=0, sel_led=4'b0001 (green), programmed=0, all_programmed=0, err=0.
- Reset also clears FSM=IDLE, both debouncers (stable level 0, counter 0) and both synchronizers.
- Reset mid-operation aborts any pending strobe; no enable may be emitted on the cycle reset is released.

Debounce, per button:
- 2-flop synchronizer, then a counter.
- While the synchronized level equals the stable level, the counter is held at 0.
- While it differs, the counter increments. On the cycle the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the new value and the counter clears.
- Any bounce back to the stable level before that point clears the counter.
- A press is a 0->1 transition of the stable level: a 1-cycle pulse. Releases generate nothing.

Selection:
- A next-press in IDLE rotates sel_led: green->arrow->red->yellow->green (wrap).
- A next-press outside IDLE is dropped.

FSM states:
- IDLE:
  - load-press with sw!=0: data_out<=sw, err<=0, go to SETUP.
  - load-press with sw==0: err<=1, data_out unchanged, no strobe, stay in IDLE.
  - load-press and next-press in the same cycle: LOAD wins, the NEXT press is discarded, and sel is unchanged.
- SETUP: one cycle; data_out stable, no enables. Go to STROBE.
- STROBE: one cycle.
  - Assert exactly the enable matching sel_led.
  - Set the matching programmed bit.
  - Go to HOLD.
- HOLD: wait until the debounced LOAD level is 0, then go to IDLE. No further strobes while LOAD is held.

Timing and data rules:
- Latency from the load-press pulse to the enable strobe is 2 cycles.
- data_out is stable from SETUP through HOLD, retains its value in IDLE, and changes only on an accepted LOAD.
- sw is sampled only on the load-press cycle; later sw changes do not affect data_out until the next LOAD.
- programmed bits are never cleared except by reset. Reprogramming a light re-strobes it and the bit stays 1.
- all_programmed is registered, and updates on the cycle after the fourth bit sets.
- At most one enable is high in any cycle.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset behaviour: drive rst=0 mid-STROBE -> all enables 0 immediately; data_out=0, sel_led=0001, programmed=0000; after release, no enable pulse appears.
- Accepted load: sw=4'd5, clean LOAD press held 20 cycles -> data_out=5 and green_enable high for exactly 1 cycle, 2 cycles after the press pulse; programmed=0001; no second strobe while held.
- Bounce rejection: LOAD toggling every 2 cycles for 20 cycles, then low -> no strobe, data_out unchanged; a glitch shorter than 4 stable cycles produces no press.
- Selection wrap: 4 NEXT presses -> sel_led 0010, 0100, 1000, 0001. Then LOAD at each position with sw=1,2,3,4 -> each matching enable strobes once; all_programmed=1 after the fourth.
- Zero rejection: sw=0 plus LOAD -> err=1, no enable, data_out holds the prior value. Then sw=7 plus LOAD -> err=0, strobe issued.
- Simultaneous presses: NEXT and LOAD press pulses in the same cycle with sel=arrow -> arrow_enable strobes and sel_led stays 0010. A NEXT press during HOLD is ignored.
